// File: rtl/exc_sched_if.sv
// ---------------------------------------------------------------------------
// exc_sched_if
//   Bundles every signal between the pipeline/CP0 side and the exception
//   scheduler. The clock and reset are not part of it.
//
//   master : pipeline/CP0 side. Drives the interrupt lines, CP0 Status/Cause
//            and the MEM-stage request fields. Receives the scheduled event.
//   slave  : exc_sched itself.
//
//   Signals
//     ext_int_i       6        raw asynchronous hardware interrupt lines
//     timer_int_i     1        CP0 timer interrupt, synchronous
//     status_i        32       CP0 Status (IE=[0], EXL=[1], IM=[15:8])
//     cause_i         32       CP0 Cause (IP=[15:8])
//     mem_valid_i     1        valid instruction in MEM stage
//     mem_exc_req_i   NREQ     exception request per slot (slot 0 highest)
//     mem_exc_code_i  NREQ*5   exception code per slot, slot k = [5k+4:5k]
//     mem_badvaddr_i  32       faulting address of the MEM instruction
//     mem_pc_i        32       PC of the MEM instruction
//     mem_in_delay_i  1        MEM instruction sits in a delay slot
//     eret_i          1        MEM instruction is ERET
//     int_pending_o   6        synchronised interrupts to CP0
//     exccode_o       5        event code to CP0
//     exc_badvaddr_o  32       faulting address to CP0
//     exc_pc_o        32       event PC to CP0
//     exc_in_delay_o  1        delay-slot flag to CP0
//     busy_o          1        high from issue cycle through end of drain
// ---------------------------------------------------------------------------
interface exc_sched_if #(
  parameter int NREQ = 4
);
  logic [5:0]        ext_int_i;
  logic              timer_int_i;
  logic [31:0]       status_i;
  logic [31:0]       cause_i;
  logic              mem_valid_i;
  logic [NREQ-1:0]   mem_exc_req_i;
  logic [NREQ*5-1:0] mem_exc_code_i;
  logic [31:0]       mem_badvaddr_i;
  logic [31:0]       mem_pc_i;
  logic              mem_in_delay_i;
  logic              eret_i;
  logic [5:0]        int_pending_o;
  logic [4:0]        exccode_o;
  logic [31:0]       exc_badvaddr_o;
  logic [31:0]       exc_pc_o;
  logic              exc_in_delay_o;
  logic              busy_o;

  modport master (
    output ext_int_i, timer_int_i, status_i, cause_i, mem_valid_i,
           mem_exc_req_i, mem_exc_code_i, mem_badvaddr_i, mem_pc_i,
           mem_in_delay_i, eret_i,
    input  int_pending_o, exccode_o, exc_badvaddr_o, exc_pc_o,
           exc_in_delay_o, busy_o
  );

  modport slave (
    input  ext_int_i, timer_int_i, status_i, cause_i, mem_valid_i,
           mem_exc_req_i, mem_exc_code_i, mem_badvaddr_i, mem_pc_i,
           mem_in_delay_i, eret_i,
    output int_pending_o, exccode_o, exc_badvaddr_o, exc_pc_o,
           exc_in_delay_o, busy_o
  );
endinterface

// File: rtl/exc_sched.sv
// ---------------------------------------------------------------------------
// exc_sched
//   Exception/interrupt scheduler in front of the CP0 register block.
//   - Synchronises the external interrupt lines and hands them to CP0.
//   - Picks one event per flush from interrupt, MEM-stage exception slots
//     and ERET, and presents it registered for exactly one cycle.
//   - Ignores further requests while the pipeline drains after an event.
//
//   Ports
//     cpu_clk_50M  in   clock
//     cpu_rst      in   asynchronous active-high reset
//     bus          exc_sched_if.slave (all request inputs and CP0 outputs)
//
//   Parameters
//     NREQ          number of MEM-stage exception slots (slot 0 highest)
//     DRAIN_CYCLES  hold-off cycles after an issued event (0 = none)
//     SYNC_STAGES   synchroniser depth on ext_int_i (>= 2)
// ---------------------------------------------------------------------------
module exc_sched #(
  parameter int NREQ         = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst,
  exc_sched_if.slave bus
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  // A zero-cycle drain still needs a 1-bit counter to keep the code legal.
  localparam int CNT_W    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int CNT_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                            state;
  logic [CNT_W-1:0]                  drain_cnt;
  logic [SYNC_STAGES-1:0][5:0]       sync_q;
  logic                              timer_q;

  logic                              int_take;
  logic                              exc_found;
  logic [4:0]                        exc_sel;
  logic                              ev_valid;
  logic [4:0]                        ev_code;

  // ------------------------------------------------------------------
  // Interrupt synchroniser. Lines are level-sensitive: nothing is held
  // here beyond the flop chain, CP0 Cause keeps IP.
  // ------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      sync_q  <= '0;
      timer_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      timer_q <= bus.timer_int_i;
    end
  end

  // Timer shares IP7 with hardware line 5.
  assign bus.int_pending_o = {sync_q[SYNC_STAGES-1][5] | timer_q,
                              sync_q[SYNC_STAGES-1][4:0]};

  // ------------------------------------------------------------------
  // Event selection (evaluated every cycle, used only in IDLE)
  // ------------------------------------------------------------------
  assign int_take = bus.mem_valid_i & bus.status_i[0] & ~bus.status_i[1] &
                    (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    exc_found = 1'b0;
    exc_sel   = EXC_NONE;
    for (int k = 0; k < NREQ; k++) begin
      if (!exc_found && bus.mem_exc_req_i[k]) begin
        exc_found = 1'b1;
        exc_sel   = bus.mem_exc_code_i[5*k +: 5];
      end
    end
  end

  always_comb begin
    ev_valid = 1'b0;
    ev_code  = EXC_NONE;
    if (int_take) begin
      ev_valid = 1'b1;
      ev_code  = EXC_INT;
    end else if (bus.mem_valid_i && exc_found) begin
      ev_valid = 1'b1;
      ev_code  = exc_sel;
    end else if (bus.mem_valid_i && bus.eret_i) begin
      ev_valid = 1'b1;
      ev_code  = EXC_ERET;
    end
  end

  // ------------------------------------------------------------------
  // Issue/drain FSM with registered outputs. Requests arriving outside
  // IDLE belong to instructions being flushed and are simply dropped.
  // ------------------------------------------------------------------
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state              <= S_IDLE;
      drain_cnt          <= '0;
      bus.exccode_o      <= EXC_NONE;
      bus.exc_badvaddr_o <= '0;
      bus.exc_pc_o       <= '0;
      bus.exc_in_delay_o <= 1'b0;
      bus.busy_o         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev_valid) begin
            state              <= S_ISSUE;
            bus.exccode_o      <= ev_code;
            bus.exc_badvaddr_o <= bus.mem_badvaddr_i;
            bus.exc_pc_o       <= bus.mem_pc_i;
            bus.exc_in_delay_o <= bus.mem_in_delay_i;
            bus.busy_o         <= 1'b1;
          end else begin
            bus.exccode_o <= EXC_NONE;
          end
        end

        S_ISSUE: begin
          bus.exccode_o <= EXC_NONE;
          if (DRAIN_CYCLES > 0) begin
            state     <= S_DRAIN;
            drain_cnt <= CNT_W'(CNT_LOAD);
          end else begin
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= S_IDLE;
            bus.busy_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.exccode_o <= EXC_NONE;
          bus.busy_o    <= 1'b0;
        end
      endcase
    end
  end

  // Status/Cause bits outside IE, EXL, IM and IP play no part here.
  logic unused_bits;
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

endmodule
